// File: rtl/det_event_logger.sv
// Detection event logger: timestamps each z pulse against a free-running
// counter, buffers the timestamps in a small FIFO drained over valid/ready,
// and keeps saturating detection/drop statistics with a sticky overflow flag.
module det_event_logger #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     z,
    input  logic                     clr,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [TS_W-1:0]          evt_ts,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [CNT_W-1:0]         det_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     ovf
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned FillW = PtrW + 1;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] det_q, det_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             ovf_q, ovf_d;

    logic full, pop, push, drop;

    // Handshake decode; fullness comes from the fill count, not pointer compare.
    always_comb begin
        full = (fill_q == FillW'(DEPTH));
        pop  = (fill_q != '0) && evt_ready;
        push = z && (!full || pop);
        drop = z && full && !pop;
    end

    // Next-state for counter, pointers, fill and statistics.
    always_comb begin
        ts_d     = ts_q + TS_W'(1);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            fill_d = fill_q + FillW'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - FillW'(1);
        end

        // clr applies first so a coincident event is counted after the clear.
        det_d  = clr ? '0 : det_q;
        drop_d = clr ? '0 : drop_q;
        ovf_d  = clr ? 1'b0 : ovf_q;
        if (z && (det_d != {CNT_W{1'b1}})) begin
            det_d = det_d + CNT_W'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_d != {CNT_W{1'b1}}) begin
                drop_d = drop_d + CNT_W'(1);
            end
        end
    end

    // State registers and FIFO storage; storage is zeroed so evt_ts reads 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            det_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ts_q     <= ts_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            det_q    <= det_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            if (push) begin
                mem_q[wr_ptr_q] <= ts_q;
            end
        end
    end

    // Outputs are straight register views; no same-cycle bypass.
    always_comb begin
        evt_valid = (fill_q != '0);
        evt_ts    = mem_q[rd_ptr_q];
        fill      = fill_q;
        det_cnt   = det_q;
        drop_cnt  = drop_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_det_event_logger.sv
// Randomized and directed bench for det_event_logger against a queue-based model.
module tb_det_event_logger;

    localparam int unsigned TS_W  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam int          TS_MOD  = 1 << TS_W;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   rst_n;
    logic                   z;
    logic                   clr;
    logic                   evt_ready;
    logic                   evt_valid;
    logic [TS_W-1:0]        evt_ts;
    logic [$clog2(DEPTH):0] fill;
    logic [CNT_W-1:0]       det_cnt;
    logic [CNT_W-1:0]       drop_cnt;
    logic                   ovf;

    det_event_logger #(
        .TS_W (TS_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .z        (z),
        .clr      (clr),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid),
        .evt_ts   (evt_ts),
        .fill     (fill),
        .det_cnt  (det_cnt),
        .drop_cnt (drop_cnt),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model state.
    int m_ts;
    int m_q[$];
    int m_det;
    int m_drop;
    int m_ovf;

    task automatic check_eq(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ts   = 0;
        m_q    = {};
        m_det  = 0;
        m_drop = 0;
        m_ovf  = 0;
    endtask

    task automatic model_edge(input bit zv, input bit cv, input bit rv);
        bit pop_m, push_m;
        pop_m  = (m_q.size() > 0) && rv;
        push_m = zv && ((m_q.size() < DEPTH) || pop_m);
        if (cv) begin
            m_det  = 0;
            m_drop = 0;
            m_ovf  = 0;
        end
        if (zv && m_det < CNT_MAX) m_det++;
        if (zv && !push_m) begin
            m_ovf = 1;
            if (m_drop < CNT_MAX) m_drop++;
        end
        if (pop_m) void'(m_q.pop_front());
        if (push_m) m_q.push_back(m_ts);
        m_ts = (m_ts + 1) % TS_MOD;
    endtask

    task automatic compare_all();
        check_eq("evt_valid", int'(evt_valid), int'(m_q.size() != 0));
        if (m_q.size() != 0) check_eq("evt_ts", int'(evt_ts), m_q[0]);
        check_eq("fill", int'(fill), m_q.size());
        check_eq("det_cnt", int'(det_cnt), m_det);
        check_eq("drop_cnt", int'(drop_cnt), m_drop);
        check_eq("ovf", int'(ovf), m_ovf);
    endtask

    // Drive inputs mid-cycle, advance one edge, compare just after it.
    task automatic step(input bit zv, input bit cv, input bit rv);
        z         = zv;
        clr       = cv;
        evt_ready = rv;
        @(posedge clk);
        model_edge(zv, cv, rv);
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        z         = 1'b0;
        clr       = 1'b0;
        evt_ready = 1'b0;
        rst_n     = 1'b0;
        #2;
        check_eq("rst_valid", int'(evt_valid), 0);
        check_eq("rst_fill", int'(fill), 0);
        check_eq("rst_ts", int'(evt_ts), 0);
        check_eq("rst_det", int'(det_cnt), 0);
        check_eq("rst_drop", int'(drop_cnt), 0);
        check_eq("rst_ovf", int'(ovf), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_until(input int t, input bit rv);
        for (int i = 0; i < TS_MOD && m_ts != t; i++) step(1'b0, 1'b0, rv);
        check_eq("idle_until_ts", m_ts, t);
    endtask

    initial begin
        rst_n     = 1'b1;
        z         = 1'b0;
        clr       = 1'b0;
        evt_ready = 1'b0;
        model_reset();
        #3;
        do_reset();

        // Idle after reset, then build fill=3 and reset mid-run.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("pre_rst_fill", int'(fill), 3);
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        check_eq("ts_restart", int'(evt_ts), 0);

        // Single pulse at ts 5 with ready held high.
        do_reset();
        idle_until(5, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check_eq("single_ts", int'(evt_ts), 5);
        check_eq("single_det", int'(det_cnt), 1);
        step(1'b0, 1'b0, 1'b1);
        check_eq("single_drained", int'(evt_valid), 0);

        // Five events at ts 10..14 with ready low: fifth dropped.
        do_reset();
        idle_until(10, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("burst_fill", int'(fill), 4);
        check_eq("burst_drop", int'(drop_cnt), 1);
        check_eq("burst_ovf", int'(ovf), 1);
        check_eq("burst_det", int'(det_cnt), 5);
        check_eq("burst_head", int'(evt_ts), 10);
        // Full FIFO with push and pop together at ts 15, then again at ts 0 (wrap).
        step(1'b1, 1'b0, 1'b1);
        check_eq("full_pp_fill", int'(fill), 4);
        check_eq("full_pp_drop", int'(drop_cnt), 1);
        step(1'b1, 1'b0, 1'b1);
        check_eq("wrap_fill", int'(fill), 4);
        check_eq("drain0", int'(evt_ts), 12);
        step(1'b0, 1'b0, 1'b1);
        check_eq("drain1", int'(evt_ts), 13);
        step(1'b0, 1'b0, 1'b1);
        check_eq("drain2", int'(evt_ts), 15);
        step(1'b0, 1'b0, 1'b1);
        check_eq("drain3_wrap", int'(evt_ts), 0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("drain_empty", int'(evt_valid), 0);

        // Saturation of det_cnt, then clr coincident with z.
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b1);
        check_eq("det_sat", int'(det_cnt), CNT_MAX);
        step(1'b1, 1'b1, 1'b1);
        check_eq("clr_det", int'(det_cnt), 1);
        check_eq("clr_drop", int'(drop_cnt), 0);
        check_eq("clr_ovf", int'(ovf), 0);
        // clr with z while full: the event is dropped after the clear.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_eq("clr_drop_det", int'(det_cnt), 1);
        check_eq("clr_drop_drop", int'(drop_cnt), 1);
        check_eq("clr_drop_ovf", int'(ovf), 1);

        // Randomized traffic with rare clears and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 99) < 45));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
